// File: rtl/fp_div_if.sv
// Handshake and operand/result bundle for the iterative half-precision divider.
interface fp_div_if;
    logic        start;
    logic [15:0] opA;
    logic [15:0] opB;
    logic [15:0] quotient;
    logic        underflow;
    logic        overflow;
    logic        inexact;
    logic        div_by_zero;
    logic        busy;
    logic        done;

    modport master (
        output start, opA, opB,
        input  quotient, underflow, overflow, inexact, div_by_zero, busy, done
    );

    modport slave (
        input  start, opA, opB,
        output quotient, underflow, overflow, inexact, div_by_zero, busy, done
    );
endinterface

// File: rtl/fp_div.sv
// Iterative IEEE-754 half-precision divider: one restoring-division quotient bit per cycle,
// fixed 14-cycle start-to-done latency, truncation rounding, no denormals.
module fp_div (
    input  logic    clock,
    input  logic    reset,
    fp_div_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_e;

    state_e             state_q;
    logic [3:0]         cnt_q;
    logic [11:0]        rem_q;
    logic [11:0]        q_q;
    logic [10:0]        mb_q;
    logic               sign_q;
    logic               a_zero_q;
    logic               b_zero_q;
    logic signed [7:0]  ediff_q;
    logic [15:0]        quotient_q;
    logic               underflow_q, overflow_q, inexact_q, div_by_zero_q;
    logic               busy_q, done_q;

    // Restoring step: the remainder stays below MB after subtraction, so bit 11 is free for the shift.
    logic               rem_ge;
    logic [11:0]        rem_sub;
    assign rem_ge  = (rem_q >= {1'b0, mb_q});
    assign rem_sub = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;

    logic signed [7:0]  e_d;
    logic [9:0]         mant_d;
    logic [15:0]        quotient_d;
    logic               underflow_d, overflow_d, inexact_d, div_by_zero_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves a latch.
        e_d           = ediff_q + 8'sd14;
        mant_d        = q_q[9:0];
        inexact_d     = (rem_q != 12'd0);
        quotient_d    = 16'h0000;
        underflow_d   = 1'b0;
        overflow_d    = 1'b0;
        div_by_zero_d = 1'b0;
        if (q_q[11]) begin
            e_d       = ediff_q + 8'sd15;
            mant_d    = q_q[10:1];
            inexact_d = q_q[0] | (rem_q != 12'd0);
        end
        if (a_zero_q && b_zero_q) begin
            quotient_d    = 16'h7E00;
            div_by_zero_d = 1'b1;
            inexact_d     = 1'b0;
        end else if (b_zero_q) begin
            quotient_d    = {sign_q, 5'd31, 10'd0};
            div_by_zero_d = 1'b1;
            inexact_d     = 1'b0;
        end else if (a_zero_q) begin
            quotient_d = {sign_q, 15'd0};
            inexact_d  = 1'b0;
        end else if (e_d >= 8'sd31) begin
            quotient_d = {sign_q, 5'd31, 10'd0};
            overflow_d = 1'b1;
        end else if (e_d <= 8'sd0) begin
            quotient_d  = {sign_q, 15'd0};
            underflow_d = 1'b1;
            inexact_d   = 1'b1;
        end else begin
            quotient_d = {sign_q, e_d[4:0], mant_d};
        end
    end

    // NOTE: all state is updated with non-blocking assignments in this single clocked block.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            rem_q         <= 12'd0;
            q_q           <= 12'd0;
            mb_q          <= 11'd0;
            sign_q        <= 1'b0;
            a_zero_q      <= 1'b0;
            b_zero_q      <= 1'b0;
            ediff_q       <= 8'sd0;
            quotient_q    <= 16'h0000;
            underflow_q   <= 1'b0;
            overflow_q    <= 1'b0;
            inexact_q     <= 1'b0;
            div_by_zero_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q       <= DIVIDE;
                        cnt_q         <= 4'd0;
                        rem_q         <= {2'b01, bus.opA[9:0]};
                        q_q           <= 12'd0;
                        mb_q          <= {1'b1, bus.opB[9:0]};
                        sign_q        <= bus.opA[15] ^ bus.opB[15];
                        a_zero_q      <= (bus.opA[14:10] == 5'd0);
                        b_zero_q      <= (bus.opB[14:10] == 5'd0);
                        ediff_q       <= $signed({3'b000, bus.opA[14:10]}) - $signed({3'b000, bus.opB[14:10]});
                        underflow_q   <= 1'b0;
                        overflow_q    <= 1'b0;
                        inexact_q     <= 1'b0;
                        div_by_zero_q <= 1'b0;
                        busy_q        <= 1'b1;
                    end
                end
                DIVIDE: begin
                    q_q   <= {q_q[10:0], rem_ge};
                    rem_q <= {rem_sub[10:0], 1'b0};
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd11) begin
                        state_q <= NORM;
                    end
                end
                NORM: begin
                    quotient_q    <= quotient_d;
                    underflow_q   <= underflow_d;
                    overflow_q    <= overflow_d;
                    inexact_q     <= inexact_d;
                    div_by_zero_q <= div_by_zero_d;
                    done_q        <= 1'b1;
                    state_q       <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.quotient    = quotient_q;
    assign bus.underflow   = underflow_q;
    assign bus.overflow    = overflow_q;
    assign bus.inexact     = inexact_q;
    assign bus.div_by_zero = div_by_zero_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: doc/fp_div.md
Name: fp_div

Overview:
- Iterative IEEE-754 half-precision divider, the inverse of the team's combinational fp_mul. Computes quotient = opA / opB.
- Uses a start/busy/done handshake with fixed latency. Produces one quotient bit per cycle through restoring division.
- Sits next to fp_mul in the PE FPU. Used for normalisation and rank-scaling divides, where multi-cycle latency is acceptable.
- Numeric conventions match fp_mul: no denormals, truncation rounding, saturation to exponent 31 on overflow.

Parameters:
- None. Quotient width is fixed at 12 bits, giving a fixed 12 divide iterations.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; opA/opB sampled on the cycle start=1 while busy=0
- opA  input  16  dividend {sign[15], exp[14:10], mant[9:0]}
- opB  input  16  divisor, same format
- quotient  output  16  result; valid when done=1, held until the next accepted start
- underflow  output  1  result flushed to zero
- overflow  output  1  result saturated to exponent 31
- inexact  output  1  nonzero bits discarded by truncation
- div_by_zero  output  1  opB is zero
- busy  output  1  high from the cycle after an accepted start through the cycle done=1
- done  output  1  one-cycle pulse: result and flags valid

Behaviour:
- Reset: state=IDLE; quotient=0, all flags=0, busy=0, done=0. A reset mid-operation aborts it; no done pulse is produced for the aborted op.
- States and transitions:
  - IDLE: start=1 moves to DIVIDE.
  - DIVIDE: runs 12 cycles, then moves to NORM.
  - NORM: 1 cycle, then moves to DONE.
  - DONE: 1 cycle with done=1, then moves to IDLE.
- Latency:
  - Start accepted at cycle 0 gives done=1 at cycle 14.
  - The next start is accepted at the earliest at cycle 15, in IDLE.
  - start while busy=1 is ignored.
- Operand capture at accept:
  - sign = sA^sB.
  - MA = {1, mA}, MB = {1, mB}.
  - eDiff = signed 7-bit eA - eB.
  - Zero detect: an operand is zero when its exponent field == 0. Mantissa is ignored (no denormals).
- DIVIDE: restoring division with remainder initialised to MA. Each cycle:
  - if rem >= MB: q bit = 1, rem = rem - MB; else q bit = 0;
  - then rem <<= 1.
  - After 12 cycles, Q[11:0] = floor(MA·2^11 / MB) and rem is the final remainder.
- NORM:
  - If Q[11]=1: mant = Q[10:1], e = eDiff + 15, inexact = Q[0] | (rem != 0).
  - Else (Q[10] is guaranteed 1): mant = Q[9:0], e = eDiff + 14, inexact = (rem != 0).
  - e >= 31: quotient = {sign, 5'd31, 10'd0}, overflow = 1.
  - e <= 0: quotient = {sign, 5'd0, 10'd0}, underflow = 1, inexact = 1.
  - Otherwise: quotient = {sign, e[4:0], mant}.
- Special cases use the same fixed latency; the divider runs but its result is overridden. Priority top-down:
  - opA zero and opB zero: quotient = 16'h7E00, div_by_zero = 1.
  - opB zero: quotient = {sign, 5'd31, 10'd0}, div_by_zero = 1.
  - opA zero: quotient = {sign, 15'd0}, all flags 0.
  - Exponent field 31 in either input is treated as an ordinary exponent (no Inf/NaN decode, same as fp_mul).
- Flags are cleared on each accepted start and held with quotient after done.

Test Plan:
- 2.0/1.0: opA=16'h4000, opB=16'h3C00 start at cycle 0 -> done exactly at cycle 14, quotient=16'h4000, all flags 0, busy high cycles 1–14.
- 1.0/3.0: opA=16'h3C00, opB=16'h4200 -> quotient=16'h3555, inexact=1, overflow=underflow=0.
- Overflow: opA=16'h7800, opB=16'h0400 (e=44) -> quotient=16'h7C00, overflow=1.
- Underflow: opA=16'h0400, opB=16'h7800 (e=-14) -> quotient=16'h0000, underflow=1, inexact=1.
- Divide by zero: opA=16'hC000, opB=16'h0000 -> quotient=16'hFC00, div_by_zero=1. Then 0/0 -> 16'h7E00, div_by_zero=1.
- Handshake/reset:
  - A second start at cycle 5 is ignored; done fires only at cycle 14 for the first op.
  - Reset at cycle 7 of a new op -> all outputs 0 next cycle, no done pulse.
  - A start 1 cycle after reset is accepted and completes 14 cycles later.
